// File: rtl/ibex_rf_loader.sv
// Load sequencer: assembles little-endian words from a byte stream and writes
// them to registers FirstAddr..LastAddr through the register file's aux port.
module ibex_rf_loader #(
  parameter int DataWidth = 32,
  parameter int FirstAddr = 1,
  parameter int LastAddr  = 31,
  parameter bit RV32E     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 s_valid_i,
  input  logic [7:0]           s_data_i,
  output logic                 s_ready_o,
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  output logic                 input_valid_o,
  output logic [4:0]           input_addr_o,
  output logic [DataWidth-1:0] input_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           dbg_state_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [4:0] FIRST = 5'(FirstAddr);
  localparam logic [4:0] LAST  = 5'(LastAddr);

  if (DataWidth != 32) begin : g_bad_width
    $error("ibex_rf_loader: DataWidth must be 32");
  end
  if (FirstAddr < 1 || FirstAddr > LastAddr || LastAddr > 31) begin : g_bad_range
    $error("ibex_rf_loader: need 1 <= FirstAddr <= LastAddr <= 31");
  end
  if (RV32E && LastAddr > 15) begin : g_bad_rv32e
    $error("ibex_rf_loader: RV32E limits LastAddr to 15");
  end

  logic [1:0]           state_q;
  logic [4:0]           addr_q;
  logic [1:0]           byte_cnt_q;
  logic [DataWidth-1:0] word_q;
  logic                 conflict;

  // Stream handshake: a byte transfers on any edge where s_valid_i && s_ready_o;
  // the source holds s_data_i stable until then, and ready depends only on state.
  assign s_ready_o     = (state_q == COLLECT);
  assign input_valid_o = (state_q == WRITE);
  assign done_o        = (state_q == DONE);
  assign busy_o        = (state_q == COLLECT) || (state_q == WRITE);
  assign input_addr_o  = (state_q == WRITE) ? addr_q : '0;
  assign input_data_o  = (state_q == WRITE) ? word_q : '0;
  assign dbg_state_o   = state_q;

  // The register file lets the core win a same-address write, so ours is lost.
  assign conflict = core_we_i && (core_waddr_i == addr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else if (abort_i) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= COLLECT;
            addr_q     <= FIRST;
            byte_cnt_q <= '0;
            word_q     <= '0;
          end
        end
        COLLECT: begin
          if (s_valid_i) begin
            word_q[{byte_cnt_q, 3'b000} +: 8] <= s_data_i;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          if (!conflict) begin
            if (addr_q == LAST) begin
              state_q <= DONE;
            end else begin
              addr_q     <= addr_q + 5'd1;
              byte_cnt_q <= '0;
              state_q    <= COLLECT;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_rf_loader.sv
// Directed bench for ibex_rf_loader: default 1..31 instance plus a 5..5 instance.
module tb_ibex_rf_loader;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        start_b = 1'b0;
  logic        abort_i = 1'b0;
  logic        s_valid_i = 1'b0;
  logic [7:0]  s_data_i = 8'h00;
  logic        core_we_i = 1'b0;
  logic [4:0]  core_waddr_i = 5'd0;

  logic        a_ready, a_valid, a_busy, a_done;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [1:0]  a_state;
  logic        b_ready, b_valid, b_busy, b_done;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [1:0]  b_state;

  int vectors = 0;
  int miscompares = 0;

  logic [4:0]  st_addr[$];
  logic [31:0] st_data[$];
  int          st_cyc[$];
  logic [31:0] mem[32];
  logic [31:0] exp_q[$];
  int          done_cnt;
  int          done_cyc;
  int          ready_bad;

  always #5 clk = ~clk;

  ibex_rf_loader dut_a (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(a_ready),
    .core_we_i(core_we_i), .core_waddr_i(core_waddr_i),
    .input_valid_o(a_valid), .input_addr_o(a_addr), .input_data_o(a_data),
    .busy_o(a_busy), .done_o(a_done), .dbg_state_o(a_state)
  );

  ibex_rf_loader #(.FirstAddr(5), .LastAddr(5)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_b), .abort_i(abort_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(b_ready),
    .core_we_i(core_we_i), .core_waddr_i(core_waddr_i),
    .input_valid_o(b_valid), .input_addr_o(b_addr), .input_data_o(b_data),
    .busy_o(b_busy), .done_o(b_done), .dbg_state_o(b_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Register k of a load that starts with byte b0 holds bytes b0+4(k-1).. +3.
  function automatic logic [31:0] exp_word(input int k, input int b0);
    int base;
    base = b0 + 4 * (k - 1);
    return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
  endfunction

  // Cycle 0 carries the start pulse; bytes are offered from cycle 1 and held until accepted.
  task automatic run_stream(input bit gaps, input int n, input int b0,
                            input int cf_cyc, input int cf_len, input logic [4:0] cf_addr,
                            input int abort_cyc, input int start2_cyc);
    int  b;
    bit  hs;
    b = b0;
    st_addr.delete();
    st_data.delete();
    st_cyc.delete();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    done_cnt = 0;
    done_cyc = -1;
    ready_bad = 0;
    for (int c = 0; c < n; c++) begin
      start_i      = (c == 0) || (c == start2_cyc);
      abort_i      = (c == abort_cyc);
      s_valid_i    = gaps ? ((c >= 1) && ((c - 1) % 3 == 0)) : (c >= 1);
      s_data_i     = 8'(b);
      core_we_i    = (c >= cf_cyc) && (c < cf_cyc + cf_len);
      core_waddr_i = cf_addr;
      if (a_valid) begin
        st_addr.push_back(a_addr);
        st_data.push_back(a_data);
        st_cyc.push_back(c);
        if (a_ready) ready_bad++;
        if (!(core_we_i && core_waddr_i == a_addr)) mem[a_addr] = a_data;
      end
      if (a_done) begin
        done_cnt++;
        done_cyc = c;
      end
      hs = s_valid_i && a_ready;
      tick();
      if (hs) b++;
    end
    start_i   = 1'b0;
    abort_i   = 1'b0;
    s_valid_i = 1'b0;
    core_we_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tick();
    tick();
    vectors++;
    if (a_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d expected 0", a_state);
    end
    vectors++;
    if ({a_ready, a_valid, a_busy, a_done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {a_ready, a_valid, a_busy, a_done});
    end
    vectors++;
    if (a_addr !== 5'd0 || a_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr %0d data %h expected 0/0", a_addr, a_data);
    end
    vectors++;
    if ({b_ready, b_valid, b_busy, b_done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags_b: got %b expected 0000", {b_ready, b_valid, b_busy, b_done});
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_full_load;
    logic [31:0] e;
    run_stream(1'b0, 160, 0, -1, 0, 5'd0, -1, -1);
    for (int k = 1; k <= 31; k++) exp_q.push_back(exp_word(k, 0));
    vectors++;
    if (st_addr.size() != 155 / 5) begin
      miscompares++;
      $display("FAIL full_strobe_count: got %0d expected 31", st_addr.size());
    end
    for (int i = 0; i < 31; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (st_addr[i] !== 5'(i + 1) || st_cyc[i] != 5 * (i + 1) || st_data[i] !== e) begin
        miscompares++;
        $display("FAIL full_strobe_%0d: got addr %0d cyc %0d data %h expected addr %0d cyc %0d data %h",
                 i, st_addr[i], st_cyc[i], st_data[i], i + 1, 5 * (i + 1), e);
      end
    end
    vectors++;
    if (mem[1] !== 32'h03020100 || mem[2] !== 32'h07060504) begin
      miscompares++;
      $display("FAIL full_regs12: got %h %h expected 03020100 07060504", mem[1], mem[2]);
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != 156) begin
      miscompares++;
      $display("FAIL full_done: got %0d pulses at %0d expected 1 at 156", done_cnt, done_cyc);
    end
    vectors++;
    if (a_state !== 2'd0 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_idle_after: got state %0d busy %b expected 0 0", a_state, a_busy);
    end
  endtask

  task automatic test_conflict;
    run_stream(1'b0, 165, 0, 15, 2, 5'd3, -1, -1);
    vectors++;
    if (st_addr.size() != 33) begin
      miscompares++;
      $display("FAIL conflict_count: got %0d expected 33", st_addr.size());
    end
    for (int i = 2; i <= 4; i++) begin
      vectors++;
      if (st_addr[i] !== 5'd3 || st_cyc[i] != 13 + i || st_data[i] !== 32'h0B0A0908) begin
        miscompares++;
        $display("FAIL conflict_retry_%0d: got addr %0d cyc %0d data %h expected 3 %0d 0b0a0908",
                 i, st_addr[i], st_cyc[i], st_data[i], 13 + i);
      end
    end
    vectors++;
    if (st_addr[5] !== 5'd4 || st_cyc[5] != 22) begin
      miscompares++;
      $display("FAIL conflict_next: got addr %0d cyc %0d expected 4 22", st_addr[5], st_cyc[5]);
    end
    vectors++;
    if (mem[3] !== 32'h0B0A0908 || mem[4] !== 32'h0F0E0D0C || mem[31] !== 32'h7B7A7978) begin
      miscompares++;
      $display("FAIL conflict_regs: got %h %h %h expected 0b0a0908 0f0e0d0c 7b7a7978",
               mem[3], mem[4], mem[31]);
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != 158) begin
      miscompares++;
      $display("FAIL conflict_done: got %0d pulses at %0d expected 1 at 158", done_cnt, done_cyc);
    end
  endtask

  task automatic test_no_conflict;
    run_stream(1'b0, 160, 0, 15, 2, 5'd4, -1, -1);
    vectors++;
    if (st_addr.size() != 31 || st_cyc[2] != 15 || st_addr[3] !== 5'd4 || st_cyc[3] != 20) begin
      miscompares++;
      $display("FAIL noconflict_timing: got n %0d cyc %0d addr %0d cyc %0d expected 31 15 4 20",
               st_addr.size(), st_cyc[2], st_addr[3], st_cyc[3]);
    end
    vectors++;
    if (done_cyc != 156) begin
      miscompares++;
      $display("FAIL noconflict_done: got %0d expected 156", done_cyc);
    end
  endtask

  task automatic test_gaps;
    int bad;
    run_stream(1'b1, 450, 0, -1, 0, 5'd0, -1, -1);
    bad = 0;
    for (int k = 1; k <= 31; k++) if (mem[k] !== exp_word(k, 0)) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL gaps_regs: got %0d wrong registers (r1 %h r31 %h) expected 0", bad, mem[1], mem[31]);
    end
    vectors++;
    if (st_addr.size() != 31 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL gaps_counts: got %0d strobes %0d done expected 31 1", st_addr.size(), done_cnt);
    end
    vectors++;
    if (ready_bad != 0) begin
      miscompares++;
      $display("FAIL gaps_ready_in_write: got %0d cycles expected 0", ready_bad);
    end
  endtask

  task automatic test_ignored_start;
    int bad;
    run_stream(1'b0, 160, 0, -1, 0, 5'd0, -1, 10);
    bad = 0;
    for (int i = 0; i < 31; i++) if (st_addr[i] !== 5'(i + 1) || st_cyc[i] != 5 * (i + 1)) bad++;
    vectors++;
    if (st_addr.size() != 31 || bad != 0 || done_cyc != 156) begin
      miscompares++;
      $display("FAIL ignored_start: got n %0d bad %0d done %0d expected 31 0 156",
               st_addr.size(), bad, done_cyc);
    end
  endtask

  task automatic test_abort;
    run_stream(1'b0, 30, 0, -1, 0, 5'd0, 23, -1);
    vectors++;
    if (st_addr.size() != 4 || st_addr[3] !== 5'd4 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL abort_no_reg5: got %0d strobes last addr %0d done %0d expected 4 4 0",
               st_addr.size(), st_addr[3], done_cnt);
    end
    vectors++;
    if (a_state !== 2'd0) begin
      miscompares++;
      $display("FAIL abort_idle: got state %0d expected 0", a_state);
    end
    run_stream(1'b0, 6, 8'hA0, -1, 0, 5'd0, -1, -1);
    vectors++;
    if (st_addr.size() != 1 || st_addr[0] !== 5'd1 || st_data[0] !== 32'hA3A2A1A0 || st_cyc[0] != 5) begin
      miscompares++;
      $display("FAIL abort_restart: got n %0d addr %0d data %h cyc %0d expected 1 1 a3a2a1a0 5",
               st_addr.size(), st_addr[0], st_data[0], st_cyc[0]);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask

  task automatic test_reset_in_write;
    run_stream(1'b0, 5, 0, -1, 0, 5'd0, -1, -1);
    vectors++;
    if (a_valid !== 1'b1 || a_addr !== 5'd1) begin
      miscompares++;
      $display("FAIL rst_write_setup: got valid %b addr %0d expected 1 1", a_valid, a_addr);
    end
    rst_i = 1'b1;
    tick();
    vectors++;
    if ({a_ready, a_valid, a_busy, a_done} !== 4'b0000 || a_addr !== 5'd0 || a_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_write: got flags %b addr %0d data %h expected 0000 0 0",
               {a_ready, a_valid, a_busy, a_done}, a_addr, a_data);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single_reg;
    logic [7:0] bytes_v[4];
    bytes_v[0] = 8'hAA;
    bytes_v[1] = 8'hBB;
    bytes_v[2] = 8'hCC;
    bytes_v[3] = 8'hDD;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = bytes_v[i];
      tick();
    end
    s_valid_i = 1'b0;
    vectors++;
    if (b_valid !== 1'b1 || b_addr !== 5'd5 || b_data !== 32'hDDCCBBAA) begin
      miscompares++;
      $display("FAIL single_strobe: got valid %b addr %0d data %h expected 1 5 ddccbbaa",
               b_valid, b_addr, b_data);
    end
    tick();
    vectors++;
    if (b_done !== 1'b1 || b_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: got done %b valid %b expected 1 0", b_done, b_valid);
    end
    tick();
    vectors++;
    if (b_state !== 2'd0 || b_done !== 1'b0 || b_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: got state %0d done %b busy %b expected 0 0 0", b_state, b_done, b_busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_conflict();
    test_no_conflict();
    test_gaps();
    test_ignored_start();
    test_abort();
    test_reset_in_write();
    test_single_reg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
